// File: rtl/dither_quant_pipe_pkg.sv
// dither_quant_pipe_pkg: dither mode type, default Bayer tile and elaboration-time channel helpers
package dither_quant_pipe_pkg;
    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ORDERED = 2'd1,
        MODE_ROUND   = 2'd2,
        MODE_RSVD    = 2'd3
    } dither_mode_e;
    localparam logic [7:0] BAYER4 [16] = '{
        8'd0,   8'd128, 8'd32,  8'd160,
        8'd192, 8'd64,  8'd224, 8'd96,
        8'd48,  8'd176, 8'd16,  8'd144,
        8'd240, 8'd112, 8'd208, 8'd80
    };
    function automatic int ch_bits(logic [31:0] cb, int c);
        return int'(cb[4*c +: 4]);
    endfunction
    function automatic int ch_lsb(logic [31:0] cb, int c);
        int s = 0;
        for (int i = 0; i < c; i++) s += ch_bits(cb, i);
        return s;
    endfunction
    function automatic int step_for_bits(int frac_w, int bits);
        return (1 << frac_w) / ((1 << bits) - 1);
    endfunction
endpackage

// File: rtl/dither_quant_pipe_if.sv
// dither_quant_pipe_if: fragment in/out valid-ready streams plus matrix config write port
//   master drives fragments, out_ready and cfg writes; slave is the dither pipe
interface dither_quant_pipe_if #(
    parameter int NUM_CH   = 3,
    parameter int IN_W     = 16,
    parameter int MAT_LOG2 = 4,
    parameter int DITH_W   = 8,
    parameter int OUT_W    = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [MAT_LOG2-1:0]      frag_x;
    logic [MAT_LOG2-1:0]      frag_y;
    logic [NUM_CH*IN_W-1:0]   color_in;
    logic [1:0]               mode;
    logic [MAT_LOG2-1:0]      x_off;
    logic [MAT_LOG2-1:0]      y_off;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_W-1:0]         color_out;
    logic                     cfg_we;
    logic [2*MAT_LOG2-1:0]    cfg_addr;
    logic [DITH_W-1:0]        cfg_wdata;
    modport master (
        output in_valid, frag_x, frag_y, color_in, mode, x_off, y_off, out_ready, cfg_we, cfg_addr, cfg_wdata,
        input  in_ready, out_valid, color_out
    );
    modport slave (
        input  in_valid, frag_x, frag_y, color_in, mode, x_off, y_off, out_ready, cfg_we, cfg_addr, cfg_wdata,
        output in_ready, out_valid, color_out
    );
endinterface

// File: rtl/dither_matrix_ram.sv
// dither_matrix_ram: 1W/1R synchronous dither matrix store, read-before-write, not reset
module dither_matrix_ram
  import dither_quant_pipe_pkg::*;
#(
  parameter int    MAT_LOG2  = 4,
  parameter int    DITH_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  re_i,
  input  logic [2*MAT_LOG2-1:0] raddr_i,
  output logic [DITH_W-1:0]     rdata_o,
  input  logic                  we_i,
  input  logic [2*MAT_LOG2-1:0] waddr_i,
  input  logic [DITH_W-1:0]     wdata_i
);
  localparam int DEPTH = 1 << (2 * MAT_LOG2);
  logic [DITH_W-1:0] mem_q [DEPTH];
  logic [DITH_W-1:0] rdata_q;
  initial begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] = DITH_W'(BAYER4[{i[MAT_LOG2 +: 2], i[1:0]}]);
  end
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/dither_quant_pipe.sv
// dither_quant_pipe: 3-stage ordered-dither + saturate + quantise of NUM_CH Q4.FRAC_W channels
//   clk, rst (async, active-high)
//   bus.slave : fragment in (valid/ready, x/y, colour, mode, x/y offsets), result out (valid/ready, colour),
//               matrix config write (we/addr/wdata)
module dither_quant_pipe
    import dither_quant_pipe_pkg::*;
#(
    parameter int                   NUM_CH    = 3,
    parameter int                   IN_W      = 16,
    parameter int                   FRAC_W    = 12,
    parameter logic [NUM_CH*4-1:0]  CH_BITS   = {4'd5, 4'd6, 4'd5},
    parameter int                   MAT_LOG2  = 4,
    parameter int                   DITH_W    = 8,
    parameter string                INIT_FILE = ""
) (
    input logic           clk,
    input logic           rst,
    dither_quant_pipe_if.slave bus
);
    localparam int OUT_W = ch_lsb(32'(CH_BITS), NUM_CH);
    localparam int OW    = FRAC_W + 1;
    localparam int SW    = IN_W + 1;
    localparam logic [SW-1:0] ONE = SW'(1) << FRAC_W;
    logic                        adv;
    logic [MAT_LOG2-1:0]         ax, ay;
    logic [DITH_W-1:0]           d;
    logic                        v0_q, v1_q, out_valid_q;
    logic [NUM_CH*IN_W-1:0]      col0_q, col1_q;
    dither_mode_e                mode0_q;
    logic [NUM_CH-1:0][OW-1:0]   off1_q, off1_d;
    logic [OUT_W-1:0]            color_out_q, color_out_d;
    // the whole pipe moves as one; a stalled output freezes every stage
    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.color_out = color_out_q;
    assign ax = bus.frag_x + bus.x_off;
    assign ay = bus.frag_y + bus.y_off;
    dither_matrix_ram #(.MAT_LOG2(MAT_LOG2), .DITH_W(DITH_W), .INIT_FILE(INIT_FILE)) u_ram (
        .clk     (clk),
        .re_i    (adv),
        .raddr_i ({ay, ax}),
        .rdata_o (d),
        .we_i    (bus.cfg_we),
        .waddr_i (bus.cfg_addr),
        .wdata_i (bus.cfg_wdata)
    );
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam int            B    = ch_bits(32'(CH_BITS), c);
        localparam int            LSB  = ch_lsb(32'(CH_BITS), c);
        localparam logic [OW-1:0] STEP = OW'(step_for_bits(FRAC_W, B));
        localparam logic [7:0]    MAXC = 8'((1 << B) - 1);
        logic [DITH_W+OW-1:0] prod0;
        logic [IN_W-1:0]      in_c;
        logic [SW-1:0]        sat, sum, clip;
        logic [SW+7:0]        prod1;
        assign prod0     = (DITH_W+OW)'(d) * (DITH_W+OW)'(STEP);
        assign off1_d[c] = mode0_q == MODE_ORDERED ? prod0[DITH_W +: OW] :
                           mode0_q == MODE_ROUND   ? STEP >> 1 : '0;
        assign in_c  = col1_q[c*IN_W +: IN_W];
        assign sat   = in_c[IN_W-1] ? '0 : ({1'b0, in_c} > ONE ? ONE : {1'b0, in_c});
        assign sum   = sat + SW'(off1_q[c]);
        assign clip  = sum > ONE ? ONE : sum;
        assign prod1 = (SW+8)'(clip) * (SW+8)'(MAXC);
        assign color_out_d[LSB +: B] = prod1[FRAC_W +: B];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            col0_q      <= '0;
            col1_q      <= '0;
            mode0_q     <= MODE_OFF;
            off1_q      <= '0;
            color_out_q <= '0;
        end else if (adv) begin
            v0_q        <= bus.in_valid;
            col0_q      <= bus.color_in;
            mode0_q     <= dither_mode_e'(bus.mode);
            v1_q        <= v0_q;
            col1_q      <= col0_q;
            off1_q      <= off1_d;
            out_valid_q <= v1_q;
            color_out_q <= color_out_d;
        end
    end
endmodule
